// File: rtl/liteeth_sram_port_arbiter.sv
// Two-client round-robin arbiter for a 1RW1R SRAM: writes go to port 0, reads to port 1; 0-cycle write, 1-cycle read, no response backpressure.
// Define LITEETH_SRAM_ARB_BYPASS_EN to forward same-cycle same-address write data to the read response.
module liteeth_sram_port_arbiter #(
  parameter int BITS       = 32,
  parameter int WORD_DEPTH = 384,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [BITS-1:0]       req0_wdata,
  output logic                  rsp0_valid,
  output logic [BITS-1:0]       rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [BITS-1:0]       req1_wdata,
  output logic                  rsp1_valid,
  output logic [BITS-1:0]       rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [BITS-1:0]       sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [BITS-1:0]       sram_dout1
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_own_q, rd_own_d;
  logic                  rd_oor_q, rd_oor_d;
  logic [1:0]            wr_err_q, wr_err_d;

  logic                  w0, w1, r0, r1;
  logic                  wg0, wg1, rg0, rg1;
  logic                  wr_any, rd_any, wr_oor, rd_oor;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [BITS-1:0]       wr_dat, rd_dat;

`ifdef LITEETH_SRAM_ARB_BYPASS_EN
  logic                  byp_vld_q, byp_vld_d;
  logic [BITS-1:0]       byp_dat_q, byp_dat_d;
`endif

  always_comb begin
    // Nothing is accepted while reset is held.
    w0 = req0_valid & req0_we & ~sys_rst;
    w1 = req1_valid & req1_we & ~sys_rst;
    r0 = req0_valid & ~req0_we & ~sys_rst;
    r1 = req1_valid & ~req1_we & ~sys_rst;

    wg0 = w0 & (~w1 | ~wr_ptr_q);
    wg1 = w1 & (~w0 | wr_ptr_q);
    rg0 = r0 & (~r1 | ~rd_ptr_q);
    rg1 = r1 & (~r0 | rd_ptr_q);

    wr_any  = wg0 | wg1;
    rd_any  = rg0 | rg1;
    wr_addr = wg1 ? req1_addr : req0_addr;
    wr_dat  = wg1 ? req1_wdata : req0_wdata;
    rd_addr = rg1 ? req1_addr : req0_addr;
    wr_oor  = wr_addr > LAST_ADDR;
    rd_oor  = rd_addr > LAST_ADDR;

    // Under contention the pointer moves to the loser; uncontended grants leave it alone.
    wr_ptr_d = wr_ptr_q;
    if (w0 & w1) wr_ptr_d = wg0;
    rd_ptr_d = rd_ptr_q;
    if (r0 & r1) rd_ptr_d = rg0;

    rd_vld_d = rd_any;
    rd_own_d = rg1;
    rd_oor_d = rd_any & rd_oor;
    wr_err_d = {wg1 & wr_oor, wg0 & wr_oor};

    req0_ready = wg0 | rg0;
    req1_ready = wg1 | rg1;

    sram_csb0  = ~(wr_any & ~wr_oor);
    sram_web0  = sram_csb0;
    sram_addr0 = sram_csb0 ? '0 : wr_addr;
    sram_din0  = sram_csb0 ? '0 : wr_dat;
    sram_csb1  = ~(rd_any & ~rd_oor);
    sram_addr1 = sram_csb1 ? '0 : rd_addr;

`ifdef LITEETH_SRAM_ARB_BYPASS_EN
    byp_vld_d = wr_any & rd_any & ~wr_oor & ~rd_oor & (wr_addr == rd_addr);
    byp_dat_d = wr_dat;
    rd_dat    = rd_oor_q ? '0 : (byp_vld_q ? byp_dat_q : sram_dout1);
`else
    rd_dat    = rd_oor_q ? '0 : sram_dout1;
`endif

    // Masking with sys_rst drops a read accepted just before reset asserts.
    rsp0_valid = rd_vld_q & ~rd_own_q & ~sys_rst;
    rsp1_valid = rd_vld_q & rd_own_q & ~sys_rst;
    rsp0_rdata = rsp0_valid ? rd_dat : '0;
    rsp1_rdata = rsp1_valid ? rd_dat : '0;
    rsp0_err   = ~sys_rst & ((rsp0_valid & rd_oor_q) | wr_err_q[0]);
    rsp1_err   = ~sys_rst & ((rsp1_valid & rd_oor_q) | wr_err_q[1]);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_own_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      wr_err_q  <= 2'b00;
`ifdef LITEETH_SRAM_ARB_BYPASS_EN
      byp_vld_q <= 1'b0;
      byp_dat_q <= '0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_vld_q  <= rd_vld_d;
      rd_own_q  <= rd_own_d;
      rd_oor_q  <= rd_oor_d;
      wr_err_q  <= wr_err_d;
`ifdef LITEETH_SRAM_ARB_BYPASS_EN
      byp_vld_q <= byp_vld_d;
      byp_dat_q <= byp_dat_d;
`endif
    end
  end

endmodule

// File: doc/liteeth_sram_port_arbiter.md
# liteeth_sram_port_arbiter

Two-requester arbiter that shares one 1RW1R 32x384 SRAM macro (liteeth packet buffer) between two clients, e.g. the MAC RX writer and the CPU/DMA bus. Writes are steered to SRAM port 0 and reads to SRAM port 1, each with its own round-robin pointer, so one write and one read can complete in the same cycle. The block sits between the clients' valid/ready command interfaces and the SRAM pins. Both SRAM clocks are tied externally to `sys_clk`.

## Interface
- `BITS`, 32, data width
- `WORD_DEPTH`, 384, number of valid words
- `ADDR_WIDTH`, 9, address width
- `sys_clk` in 1: clock for the arbiter and both SRAM ports
- `sys_rst` in 1: synchronous, active-high reset
- `reqN_valid` in 1 (N=0,1): command valid
- `reqN_ready` out 1: command accepted this cycle when `valid & ready`
- `reqN_we` in 1: 1 = write, 0 = read
- `reqN_addr` in ADDR_WIDTH: word address
- `reqN_wdata` in BITS: write data
- `rspN_valid` out 1: one-cycle read-response strobe
- `rspN_rdata` out BITS: read data, valid only with `rspN_valid`
- `rspN_err` out 1: one-cycle strobe for an out-of-range access (read or write)
- `sram_csb0`, `sram_web0` out 1: port 0 active-low select and write enable
- `sram_addr0` out ADDR_WIDTH, `sram_din0` out BITS: port 0 address and data
- `sram_csb1` out 1, `sram_addr1` out ADDR_WIDTH: port 1 select and address
- `sram_dout1` in BITS: port 1 registered read data

## Operation
- **Classification.** Each cycle, every valid request is classed as write (`we=1`) or read (`we=0`).
- **Write arbitration.**
  - If exactly one requester presents a write, it is granted.
  - If both present a write, the one selected by `wr_ptr` is granted.
  - After any grant made while both were contending, `wr_ptr` points to the loser.
  - An uncontended grant leaves `wr_ptr` unchanged.
- **Read arbitration.** Identical scheme using `rd_ptr`, independent of `wr_ptr`.
- **Readiness.** `reqN_ready` = requester N holds the write grant or the read grant. A requester has at most one command per cycle, so at most one of the two grants can be its own.
- **Write grant drives port 0:** `sram_csb0=0`, `sram_web0=0`, `sram_addr0`/`sram_din0` from the granted requester.
- **Read grant drives port 1:** `sram_csb1=0`, `sram_addr1` from the granted requester.
- **Idle ports:** `csb=1`, `web0=1`, address and data driven to 0.
- **Out-of-range (`addr >= WORD_DEPTH`, i.e. 384..511):**
  - The command is still granted and consumes its arbitration slot.
  - The SRAM is not selected (`csb` stays 1).
  - Write: `rspN_err` pulses the next cycle.
  - Read: `rspN_valid` and `rspN_err` pulse together the next cycle with `rspN_rdata=0`.
- **Read response.** A registered tag `{valid, owner, oor}` captures the read grant. Next cycle, `rsp<owner>_valid=1` and `rdata=sram_dout1`. Responses have no backpressure.
- **Same-cycle read and write to one address** (default build): the read returns the old contents, i.e. read-before-write.
- **Reset values:**
  - All `ready`, `rsp*_valid` and `rsp*_err` outputs are 0; `rsp*_rdata` is 0.
  - `sram_csb0=sram_csb1=sram_web0=1`.
  - `wr_ptr=rd_ptr=0` (requester 0 favoured first).
  - The pending read tag is cleared.
- **Reset mid-operation.** A read accepted in the cycle before reset asserts produces no response. Commands presented while `sys_rst=1` are not accepted.

## Timing
- Grant and `ready` are combinational from `valid`, `we`, `addr` and the pointers. There is no registered request stage.
- SRAM control and address outputs are combinational from the grants and are sampled by the SRAM at the same `sys_clk` edge that accepts the command.
- Write latency is 0: the data is in the array after the accepting edge.
- Read latency is exactly 1 cycle, accept edge to `rsp_valid`.
- Sustained throughput is 1 write plus 1 read per cycle. Under contention each requester receives every second grant of that type.
- `wr_ptr`, `rd_ptr` and the response tag update only on `sys_clk` rising edges.

## Configuration
- **`LITEETH_SRAM_ARB_BYPASS_EN` defined:**
  - When a granted read and a granted write target the same in-range address in one cycle, the write data is registered.
  - The next-cycle response returns that data instead of `sram_dout1` (write-first semantics).
  - Adds one BITS-wide register and one flag.
- **Macro undefined:** read-before-write as described above; no forwarding logic is present.

## Test plan
- Reset: hold `sys_rst` for 3 cycles with both requesters valid. Required: `ready=0`, `csb0=csb1=1`, no `rsp`. On release both pointers favour requester 0.
- Write then read: req0 writes 0xDEADBEEF to address 5; next cycle req1 reads address 5. Required: one cycle later `rsp1_valid=1`, `rsp1_rdata=0xDEADBEEF`, `rsp0_valid=0`.
- Write contention: both requesters write continuously for 6 cycles (addresses 10/20). Required: grants alternate 0,1,0,1,0,1; final contents equal the last accepted write of each requester.
- Concurrent ports: req0 writes address 7 while req1 reads address 3 in the same cycle. Required: both `ready=1` in that cycle, and `rsp1` returns the prior contents of address 3.
- Same-address collision: address 9 holds 0x1; req0 writes 0x2 to 9 while req1 reads 9. Required: response 0x1 without `LITEETH_SRAM_ARB_BYPASS_EN`, 0x2 with it.
- Out-of-range: req0 reads address 384 and req1 writes address 511. Required: both `ready=1` and `csb0=csb1=1`; next cycle `rsp0_valid=1`, `rsp0_err=1`, `rsp0_rdata=0` and `rsp1_err=1`; no SRAM contents change.
